arm_memory: RTL and testbench
=============================

ARM_MEMORY -- requirements
Module: arm_memory

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 10, meaning the word-address width of internal storage (2^ADDR_BITS 32-bit words).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to ack; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port inst_req  input  1  fetch request, held high until inst_ack.
REQ-006 Port inst_addr  input  30  fetch word address.
REQ-007 Port inst  output  32  fetched instruction word.
REQ-008 Port inst_ack  output  1  one-cycle fetch completion pulse.
REQ-009 Port mem_req  input  1  data request, held high until mem_ack.
REQ-010 Port mem_we  input  1  1 = store, 0 = load.
REQ-011 Port mem_be  input  4  store byte enables; bit i selects bits [8i+7:8i].
REQ-012 Port mem_addr  input  30  data word address.
REQ-013 Port mem_data_in  input  32  store data.
REQ-014 Port mem_data_out  output  32  load data.
REQ-015 Port mem_ack  output  1  one-cycle data completion pulse.
REQ-016 Port mem_err  output  1  out-of-range flag, valid in the mem_ack cycle.

Function
REQ-017 Storage SHALL be one single-ported array of 2^ADDR_BITS words serving both ports, at most one access in progress.
REQ-018 FSM states SHALL be IDLE, WAIT, ACK.
REQ-019 IDLE: mem_req high -> accept data request; else inst_req high -> accept fetch; else stay IDLE.
REQ-020 On acceptance, owner (DATA/FETCH), address, we, be and store data SHALL be latched; later input changes SHALL be ignored until ack.
REQ-021 Acceptance SHALL load a wait counter; the ack pulse SHALL occur exactly LATENCY cycles after the accepting edge (LATENCY=1: ack in the next cycle; WAIT is skipped).
REQ-022 ACK state SHALL last exactly one cycle with the owner's ack high, then return to IDLE; no request is accepted in the ACK cycle.
REQ-023 A req still high in the first IDLE cycle after ack SHALL be treated as a new request.
REQ-024 Simultaneous mem_req and inst_req in IDLE -> data served first; a pending fetch SHALL be accepted on the next IDLE cycle with no data request pending.
REQ-025 Load: mem_data_out SHALL update to the addressed word at the edge entering ACK and hold until the next data ack.
REQ-026 Store: enabled bytes SHALL be written at the edge entering ACK; disabled bytes unchanged; mem_data_out SHALL not change on stores.
REQ-027 Fetch: inst SHALL update at the edge entering ACK and hold until the next fetch ack.
REQ-028 Address bits [29:ADDR_BITS] nonzero -> out of range: stores suppressed, loads and fetches return 32'h0, mem_err high with mem_ack (data only); in-range -> mem_err low.
REQ-029 Ack timing and latency SHALL be identical for in-range and out-of-range accesses.

Reset
REQ-030 rst high at an edge SHALL force IDLE, counter 0, inst_ack=0, mem_ack=0, mem_err=0, inst=0, mem_data_out=0.
REQ-031 rst during WAIT SHALL abort the access: no store committed, no ack issued.
REQ-032 Storage contents SHALL NOT be altered by rst.
REQ-033 rst SHALL take priority over any request in the same cycle.

Verification
REQ-034 Store addr 5, data 32'hDEADBEEF, be 4'hF, then load addr 5 -> mem_ack exactly LATENCY cycles after each accept, mem_data_out=32'hDEADBEEF, mem_err=0.
REQ-035 Word 5 = 32'h11223344, store 32'hAABBCCDD be 4'b0101, load -> 32'h11BB33DD.
REQ-036 mem_req and inst_req raised same cycle (both held) -> mem_ack first, inst_ack LATENCY+1 cycles later.
REQ-037 Store 32'h12345678 to addr 30'h400 (ADDR_BITS=10) -> mem_err=1 with mem_ack; load of word 0 unchanged; load addr 30'h400 -> 32'h0, mem_err=1.
REQ-038 LATENCY=4, store accepted, rst pulsed 2 cycles later -> no mem_ack, target word unchanged, all outputs 0.
REQ-039 inst_req held high continuously, addr 0 -> inst_ack every LATENCY+1 cycles, inst equals preloaded word 0 each time.

Source files
------------

// File: rtl/arm_memory.sv
// Shared single-ported instruction/data word memory with a fixed access latency.
// Data requests win arbitration over fetches; only one access is ever in flight.
//
// state | meaning
// IDLE  | nothing in flight; arbitrates mem_req over inst_req
// WAIT  | access accepted, wait counter running down
// ACK   | one-cycle completion pulse to the owning port

module arm_memory #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [29:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_be,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        mem_ack,
    output logic        mem_err
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        owner_data_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;

    logic        err_q;
    logic [31:0] inst_q;
    logic [31:0] rdata_q;

    logic [31:0] mem_q [DEPTH];

    logic                 accept;
    logic                 enter_ack;
    logic                 eff_data;
    logic                 eff_we;
    logic [3:0]           eff_be;
    logic [29:0]          eff_addr;
    logic [31:0]          eff_wdata;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          rd_word;

    // In IDLE the access comes straight from the ports: with LATENCY=1 the
    // accepting edge is also the edge that enters ACK and commits the access.
    always_comb begin
        if (state_q == IDLE) begin
            eff_data  = mem_req;
            eff_we    = mem_req & mem_we;
            eff_be    = mem_be;
            eff_addr  = mem_req ? mem_addr : inst_addr;
            eff_wdata = mem_data_in;
        end else begin
            eff_data  = owner_data_q;
            eff_we    = we_q;
            eff_be    = be_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
        end
    end

    assign in_range = (eff_addr >> ADDR_BITS) == 30'd0;
    assign idx      = eff_addr[ADDR_BITS-1:0];
    assign rd_word  = in_range ? mem_q[idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req || inst_req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d   = ACK;
                        cnt_d     = 4'd0;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_data_q <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            addr_q       <= 30'd0;
            wdata_q      <= 32'd0;
        end else if (accept) begin
            owner_data_q <= eff_data;
            we_q         <= eff_we;
            be_q         <= eff_be;
            addr_q       <= eff_addr;
            wdata_q      <= eff_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_ack) begin
            if (eff_data) begin
                err_q <= !in_range;
                if (!eff_we) begin
                    rdata_q <= rd_word;
                end
            end else begin
                inst_q <= rd_word;
            end
        end
    end

    // Storage is never reset; a reset in the commit cycle drops the store.
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && eff_data && eff_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) begin
                    mem_q[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        mem_ack      = (state_q == ACK) && owner_data_q;
        inst_ack     = (state_q == ACK) && !owner_data_q;
        mem_err      = (state_q == ACK) && owner_data_q && err_q;
        inst         = inst_q;
        mem_data_out = rdata_q;
    end

endmodule

// File: tb/tb_arm_memory.sv
// Scoreboard bench for arm_memory at LATENCY 1, 2 and 4; each instance is exercised in turn.
module tb_arm_memory;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_s        [3];
    logic        inst_req_s   [3];
    logic [29:0] inst_addr_s  [3];
    logic [31:0] inst_s       [3];
    logic        inst_ack_s   [3];
    logic        mem_req_s    [3];
    logic        mem_we_s     [3];
    logic [3:0]  mem_be_s     [3];
    logic [29:0] mem_addr_s   [3];
    logic [31:0] mem_wdata_s  [3];
    logic [31:0] mem_rdata_s  [3];
    logic        mem_ack_s    [3];
    logic        mem_err_s    [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            arm_memory #(
                .ADDR_BITS(10),
                .LATENCY  (g == 0 ? 1 : (g == 1 ? 2 : 4))
            ) u_dut (
                .clk         (clk),
                .rst         (rst_s[g]),
                .inst_req    (inst_req_s[g]),
                .inst_addr   (inst_addr_s[g]),
                .inst        (inst_s[g]),
                .inst_ack    (inst_ack_s[g]),
                .mem_req     (mem_req_s[g]),
                .mem_we      (mem_we_s[g]),
                .mem_be      (mem_be_s[g]),
                .mem_addr    (mem_addr_s[g]),
                .mem_data_in (mem_wdata_s[g]),
                .mem_data_out(mem_rdata_s[g]),
                .mem_ack     (mem_ack_s[g]),
                .mem_err     (mem_err_s[g])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;
    int cur_d    = 0;
    int lat      = 1;

    exp_t        mq [$];
    exp_t        iq [$];
    logic [31:0] shadow    [3][1024];
    logic [31:0] last_load [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lat=%0d observed=%h expected=%h", tag, lat, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lat=%0d observed=%b expected=%b", tag, lat, obs, exp);
        end
    endtask

    // Drive a data request and push what the model says it must return.
    task automatic drive_mem(input int d, input logic we, input logic [3:0] be,
                             input logic [29:0] addr, input logic [31:0] data, input int exp_cyc);
        exp_t e;
        logic oor;
        oor = (addr[29:10] != 20'd0);
        mem_req_s[d]   = 1'b1;
        mem_we_s[d]    = we;
        mem_be_s[d]    = be;
        mem_addr_s[d]  = addr;
        mem_wdata_s[d] = data;
        if (we) begin
            if (!oor) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) shadow[d][addr[9:0]][8*b +: 8] = data[8*b +: 8];
            end
        end else begin
            last_load[d] = oor ? 32'h0 : shadow[d][addr[9:0]];
        end
        e.data = last_load[d];
        e.err  = oor;
        e.cyc  = exp_cyc;
        mq.push_back(e);
    endtask

    task automatic drive_fetch(input int d, input logic [29:0] addr, input int exp_cyc);
        exp_t e;
        inst_req_s[d]  = 1'b1;
        inst_addr_s[d] = addr;
        e.data = (addr[29:10] != 20'd0) ? 32'h0 : shadow[d][addr[9:0]];
        e.err  = 1'b0;
        e.cyc  = exp_cyc;
        iq.push_back(e);
    endtask

    // Watch acks until both queues drain, dropping each req once its port is done.
    task automatic run(input int d, input int budget);
        exp_t e;
        int   n = 0;
        logic done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (mem_ack_s[d]) begin
                if (mq.size() == 0) begin
                    chk1("spurious_mem_ack", mem_ack_s[d], 1'b0);
                end else begin
                    e = mq.pop_front();
                    chk("mem_ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mem_data_out", mem_rdata_s[d], e.data);
                    chk1("mem_err", mem_err_s[d], e.err);
                    if (mq.size() == 0) mem_req_s[d] = 1'b0;
                end
            end
            if (inst_ack_s[d]) begin
                if (iq.size() == 0) begin
                    chk1("spurious_inst_ack", inst_ack_s[d], 1'b0);
                end else begin
                    e = iq.pop_front();
                    chk("inst_ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("inst", inst_s[d], e.data);
                    chk1("mem_err_on_fetch", mem_err_s[d], 1'b0);
                    if (iq.size() == 0) inst_req_s[d] = 1'b0;
                end
            end
            done = (mq.size() == 0) && (iq.size() == 0);
        end
        chk1("ack_timeout", done, 1'b1);
        mq.delete();
        iq.delete();
        mem_req_s[d]  = 1'b0;
        inst_req_s[d] = 1'b0;
    endtask

    task automatic mem_op(input int d, input logic we, input logic [3:0] be,
                          input logic [29:0] addr, input logic [31:0] data);
        @(negedge clk);
        drive_mem(d, we, be, addr, data, cyc + lat);
        run(d, 40);
    endtask

    task automatic fetch_op(input int d, input logic [29:0] addr);
        @(negedge clk);
        drive_fetch(d, addr, cyc + lat);
        run(d, 40);
    endtask

    task automatic chk_reset_outputs(input int d, input string tag);
        chk({tag, "_inst"}, inst_s[d], 32'h0);
        chk({tag, "_mem_data_out"}, mem_rdata_s[d], 32'h0);
        chk1({tag, "_inst_ack"}, inst_ack_s[d], 1'b0);
        chk1({tag, "_mem_ack"}, mem_ack_s[d], 1'b0);
        chk1({tag, "_mem_err"}, mem_err_s[d], 1'b0);
    endtask

    initial begin
        int   c;
        logic saw;
        for (int i = 0; i < 3; i++) begin
            rst_s[i]       = 1'b1;
            inst_req_s[i]  = 1'b0;
            inst_addr_s[i] = 30'd0;
            mem_req_s[i]   = 1'b0;
            mem_we_s[i]    = 1'b0;
            mem_be_s[i]    = 4'd0;
            mem_addr_s[i]  = 30'd0;
            mem_wdata_s[i] = 32'd0;
            last_load[i]   = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

        for (int d = 0; d < 3; d++) begin
            cur_d = d;
            lat   = lat_of(d);

            rst_s[d] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk_reset_outputs(d, "reset");
            rst_s[d] = 1'b0;
            last_load[d] = 32'h0;

            mem_op(d, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF);
            mem_op(d, 1'b0, 4'h0, 30'd5, 32'h0);

            mem_op(d, 1'b1, 4'hF, 30'd5, 32'h11223344);
            mem_op(d, 1'b1, 4'b0101, 30'd5, 32'hAABBCCDD);
            mem_op(d, 1'b0, 4'h0, 30'd5, 32'h0);
            chk("byte_merge", mem_rdata_s[d], 32'h11BB33DD);

            mem_op(d, 1'b1, 4'hF, 30'd0, 32'hA5A50000 | 32'(d));

            @(negedge clk);
            c = cyc;
            drive_mem(d, 1'b0, 4'h0, 30'd5, 32'h0, c + lat);
            drive_fetch(d, 30'd0, c + 2 * lat + 1);
            run(d, 40);

            mem_op(d, 1'b1, 4'hF, 30'h400, 32'h12345678);
            mem_op(d, 1'b0, 4'h0, 30'd0, 32'h0);
            mem_op(d, 1'b0, 4'h0, 30'h400, 32'h0);
            fetch_op(d, 30'h400);

            @(negedge clk);
            c = cyc;
            for (int k = 0; k < 4; k++) drive_fetch(d, 30'd0, c + lat + k * (lat + 1));
            run(d, 64);

            if (lat >= 3) begin
                mem_op(d, 1'b1, 4'hF, 30'd7, 32'h77777777);
                @(negedge clk);
                mem_req_s[d]   = 1'b1;
                mem_we_s[d]    = 1'b1;
                mem_be_s[d]    = 4'hF;
                mem_addr_s[d]  = 30'd7;
                mem_wdata_s[d] = 32'hBAD0BAD0;
                @(negedge clk);
                mem_req_s[d] = 1'b0;
                mem_we_s[d]  = 1'b0;
                @(negedge clk);
                rst_s[d] = 1'b1;
                @(negedge clk);
                chk_reset_outputs(d, "abort");
                rst_s[d] = 1'b0;
                last_load[d] = 32'h0;
                saw = 1'b0;
                repeat (lat + 4) begin
                    @(negedge clk);
                    saw = saw | mem_ack_s[d] | inst_ack_s[d];
                end
                chk1("abort_no_ack", saw, 1'b0);
                mem_op(d, 1'b0, 4'h0, 30'd7, 32'h0);
                chk("abort_word_kept", mem_rdata_s[d], 32'h77777777);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
